// File: rtl/decoder_pkg.sv
// Shared definitions for the decode queue: field offsets, the branch-class
// bit position and the decoded-bundle record stored in each queue entry.
// Optional feature macro: DECODE_ILLEGAL_EN adds a per-entry illegal flag.
package decoder_pkg;

  localparam int OP_WIDTH      = 4;
  localparam int IMM_WIDTH     = 16;
  // Widest register specifier the stored bundle can carry; narrower
  // specifiers occupy the low bits and the rest stay zero.
  localparam int MAX_REG_WIDTH = 8;

  // Field positions, expressed as MSB indices relative to the word width.
  function automatic int op1Msb(input int w);
    return w - 1;
  endfunction

  function automatic int op2Msb(input int w);
    return w - 5;
  endfunction

  function automatic int fieldAMsb(input int w);
    return w - 9;
  endfunction

  function automatic int fieldBMsb(input int w, input int r);
    return w - 9 - r;
  endfunction

  function automatic int fieldCMsb(input int w, input int r);
    return w - 9 - 2 * r;
  endfunction

  // A set bit here marks a branch-class instruction, which swaps the
  // source specifier selection.
  function automatic int branchBit(input int w);
    return w - 2;
  endfunction

  typedef struct packed {
    logic [OP_WIDTH-1:0]      op1;
    logic [OP_WIDTH-1:0]      op2;
    logic [MAX_REG_WIDTH-1:0] rd;
    logic [MAX_REG_WIDTH-1:0] rs1;
    logic [MAX_REG_WIDTH-1:0] rs2;
    logic [IMM_WIDTH-1:0]     imm16;
`ifdef DECODE_ILLEGAL_EN
    logic                     illegal;
`endif
  } decoded_t;

endpackage

// File: rtl/field_extract.sv
// Pure combinational field extraction for one instruction word, producing
// the decoded bundle that the queue stores.
// Optional feature macro: DECODE_ILLEGAL_EN adds the illegal-opcode flag.
module field_extract
  import decoder_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int REG_WIDTH   = 4
`ifdef DECODE_ILLEGAL_EN
  ,
  parameter logic [15:0] LEGAL_OP1_MASK = 16'hFFFF
`endif
) (
  input  logic [INSTR_WIDTH-1:0] instr_i,
  output decoded_t               bundle_o
);

  localparam int OP1_MSB = op1Msb(INSTR_WIDTH);
  localparam int OP2_MSB = op2Msb(INSTR_WIDTH);
  localparam int A_MSB   = fieldAMsb(INSTR_WIDTH);
  localparam int B_MSB   = fieldBMsb(INSTR_WIDTH, REG_WIDTH);
  localparam int C_MSB   = fieldCMsb(INSTR_WIDTH, REG_WIDTH);
  localparam int BR_BIT  = branchBit(INSTR_WIDTH);

  logic [OP_WIDTH-1:0]  op1Field;
  logic [OP_WIDTH-1:0]  op2Field;
  logic [REG_WIDTH-1:0] fieldA;
  logic [REG_WIDTH-1:0] fieldB;
  logic [REG_WIDTH-1:0] fieldC;
  logic                 isBranch;
  logic                 unusedInstr;

  assign op1Field = instr_i[OP1_MSB -: OP_WIDTH];
  assign op2Field = instr_i[OP2_MSB -: OP_WIDTH];
  assign fieldA   = instr_i[A_MSB -: REG_WIDTH];
  assign fieldB   = instr_i[B_MSB -: REG_WIDTH];
  assign fieldC   = instr_i[C_MSB -: REG_WIDTH];
  assign isBranch = instr_i[BR_BIT];

  // Some widths leave gap bits between the specifiers and the immediate.
  assign unusedInstr = ^instr_i;

  // Assemble the bundle; branches read their sources from A/B, others from B/C.
  always_comb begin
    bundle_o       = '0;
    bundle_o.op1   = op1Field;
    bundle_o.op2   = op2Field;
    bundle_o.rd[REG_WIDTH-1:0] = fieldA;
    if (isBranch) begin
      bundle_o.rs1[REG_WIDTH-1:0] = fieldA;
      bundle_o.rs2[REG_WIDTH-1:0] = fieldB;
    end else begin
      bundle_o.rs1[REG_WIDTH-1:0] = fieldB;
      bundle_o.rs2[REG_WIDTH-1:0] = fieldC;
    end
    bundle_o.imm16 = instr_i[IMM_WIDTH-1:0];
`ifdef DECODE_ILLEGAL_EN
    bundle_o.illegal = ~LEGAL_OP1_MASK[op1Field];
`endif
  end

endmodule

// File: rtl/decode_queue.sv
// Decode queue: instructions are decoded as they are pushed and the decoded
// bundles are held in a small circular buffer; the head is presented
// combinationally with a valid/ready handshake on each side.
// Optional feature macro: DECODE_ILLEGAL_EN adds LEGAL_OP1_MASK and 'illegal'.
module decode_queue
  import decoder_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int REG_WIDTH   = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4
`ifdef DECODE_ILLEGAL_EN
  ,
  parameter logic [15:0] LEGAL_OP1_MASK = 16'hFFFF
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             op1,
  output logic [3:0]             op2,
  output logic [REG_WIDTH-1:0]   rd,
  output logic [REG_WIDTH-1:0]   rs1,
  output logic [REG_WIDTH-1:0]   rs2,
  output logic [15:0]            imm16,
  output logic [DATA_WIDTH-1:0]  imm_ext,
  output logic [$clog2(DEPTH):0] count
`ifdef DECODE_ILLEGAL_EN
  ,
  output logic                   illegal
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = 1;
  localparam logic [CNT_W-1:0] CNT_ONE   = 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  decoded_t             mem_q [DEPTH];
  decoded_t             pushEntry;
  decoded_t             head;
  logic [PTR_W-1:0]     wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]     rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 doPush;
  logic                 doPop;
  logic                 unusedHead;

  field_extract #(
    .INSTR_WIDTH(INSTR_WIDTH),
    .REG_WIDTH  (REG_WIDTH)
`ifdef DECODE_ILLEGAL_EN
    ,
    .LEGAL_OP1_MASK(LEGAL_OP1_MASK)
`endif
  ) u_extract (
    .instr_i (in_instr),
    .bundle_o(pushEntry)
  );

  assign in_ready  = (count_q < DEPTH_CNT);
  assign out_valid = (count_q != '0);
  assign doPush    = in_valid & in_ready;
  assign doPop     = out_valid & out_ready;

  // Pointer and occupancy update; flush discards any same-cycle handshakes.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
      if (doPop)  rdPtr_d = rdPtr_q + PTR_ONE;
      if (doPush && !doPop)      count_d = count_q + CNT_ONE;
      else if (doPop && !doPush) count_d = count_q - CNT_ONE;
    end
  end

  // Control state register; reset overrides flush and handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage is never cleared; only accepted, non-flushed pushes write it.
  always_ff @(posedge clk) begin
    if (!reset && !flush && doPush) begin
      mem_q[wrPtr_q] <= pushEntry;
    end
  end

  assign head       = mem_q[rdPtr_q];
  assign unusedHead = ^head;

  // Head fields straight from storage; imm_ext is the sign-extended immediate.
  always_comb begin
    op1     = head.op1;
    op2     = head.op2;
    rd      = head.rd[REG_WIDTH-1:0];
    rs1     = head.rs1[REG_WIDTH-1:0];
    rs2     = head.rs2[REG_WIDTH-1:0];
    imm16   = head.imm16;
    imm_ext = DATA_WIDTH'($signed(head.imm16));
`ifdef DECODE_ILLEGAL_EN
    illegal = head.illegal;
`endif
  end

  assign count = count_q;

endmodule
